mby_egr_mc_table_req_arb: RTL and testbench
===========================================

// Module: mby_egr_mc_table_req_arb
// PURPOSE
//  N-channel egress requester to the MultiCast Shared Table. Round-robin arbitrates channel lookups
//  and issues one tagged request per grant, with a credit-limited number of outstanding requests.
//  Accepts out-of-order tagged responses and returns each to its owning channel.
//  Sits in EGR between the per-port MC replication engines and the shared MC table.
// PARAMETERS
//  N_CH       4    number of egress requesting channels (2..16)
//  ADDR_W     14   MC table index width
//  DATA_W     64   MC table entry width
//  MAX_OUTST  8    max outstanding requests; power of 2, 2..32
//  TAG_W      $clog2(MAX_OUTST)  request/response tag width (derived)
//  TMO_CYC    1024 timeout threshold in cycles; used only with MBY_EGR_MC_TABLE_TIMEOUT_EN
// PORTS
//  cclk          in   1              core clock; all logic on rising edge
//  rst           in   1              asynchronous, active-high reset
//  ch_req_vld    in   N_CH           per-channel lookup request valid
//  ch_req_addr   in   N_CH*ADDR_W    per-channel table index; channel i at [i*ADDR_W +: ADDR_W]
//  ch_req_rdy    out  N_CH           per-channel accept; one-hot or zero (grant)
//  tbl_req_vld   out  1              request to table valid
//  tbl_req_addr  out  ADDR_W         request index
//  tbl_req_tag   out  TAG_W          request tag
//  tbl_req_ack   in   1              table accepts current request this cycle
//  tbl_rsp_vld   in   1              table response valid
//  tbl_rsp_tag   in   TAG_W          tag of response
//  tbl_rsp_data  in   DATA_W         table entry
//  ch_rsp_vld    out  N_CH           one-hot response strobe to owning channel
//  ch_rsp_data   out  DATA_W         response data, shared by all channels
//  outst_cnt     out  TAG_W+1        number of allocated tags
//  err_bad_tag   out  1              sticky: response received on an unallocated tag
//  err_timeout   out  1              sticky: tag timed out (tied 0 when macro is undefined)
// BEHAVIOUR
//  Reset: all outputs 0; all tags free; RR pointer = 0; FSM in IDLE.
//  FSM: IDLE -> ISSUE on grant. ISSUE -> IDLE on tbl_req_ack with no new grant.
//    ISSUE -> ISSUE on tbl_req_ack with a same-cycle new grant (back-to-back).
//  Grant condition: (IDLE or tbl_req_ack) and a free tag exists and any ch_req_vld.
//  Grant target: first requesting channel at or after the RR pointer.
//    ch_req_rdy[g] = 1 combinationally. RR pointer becomes (g+1) mod N_CH.
//  Request latency: a request accepted at cycle T appears on tbl_req_* at T+1.
//  Request hold: tbl_req_vld/addr/tag stay stable until tbl_req_ack.
//  Tag allocation: on grant, allocate the lowest free tag; owner[tag] = g; outst_cnt increments.
//  Response on an allocated tag at cycle T:
//    ch_rsp_vld[owner] = 1 and ch_rsp_data registered at T+1; tag freed at T+1.
//  Response on a free tag: dropped; err_bad_tag set; outst_cnt unchanged.
//  Full: outst_cnt == MAX_OUTST -> ch_req_rdy = 0. The current ISSUE request still completes.
//  Simultaneous allocate and free in one cycle: both take effect; outst_cnt is net-unchanged.
//    A freed tag becomes allocatable from the next cycle only.
//  Responses are never back-pressured; one response per cycle maximum.
//  Reset asserted mid-operation: in-flight tags are discarded; later responses set err_bad_tag.
// CONFIGURATION
//  MBY_EGR_MC_TABLE_TIMEOUT_EN defined:
//    Per-tag age counter runs while the tag is allocated.
//    When the count reaches TMO_CYC: tag freed, err_timeout set, no ch_rsp_vld.
//    A late response on that tag is treated as an unallocated tag.
//  MBY_EGR_MC_TABLE_TIMEOUT_EN undefined: no counters; err_timeout tied 0.
// STRUCTURE
//  mby_egr_pkg: typedefs mc_tbl_req_t {addr,tag} and mc_tbl_rsp_t {tag,data};
//    constants MC_TBL_ADDR_W and MC_TBL_DATA_W.
//  Sub-module mby_egr_rr_arb: generic N-way round-robin arbiter (req, gnt, advance).
//  Tag free-list, owner table and FSM stay in this module.
// TESTING
//  1. Single request: ch1 req addr=0x12, ack at T+3, rsp tag 0 at T+6
//     -> tbl_req at T+1, held until T+3; ch_rsp_vld=0010 at T+7; outst_cnt 1 -> 0.
//  2. All 4 channels requesting, ack every cycle
//     -> grants 0,1,2,3,0 in order; tags 0,1,2,3,4.
//  3. Fill 8 tags, no responses -> ch_req_rdy = 0 after the 8th grant.
//     Then rsp tag 5 -> tag 5 is regranted on the following cycle.
//  4. Out-of-order responses for tags 3,0,2 -> each routed to its recorded owner;
//     data matches per tag.
//  5. rsp on free tag 6 -> no ch_rsp_vld; err_bad_tag = 1 and stays set.
//  6. Macro on, TMO_CYC=16, no rsp -> err_timeout at cycle 16 after issue; tag freed.
//     Assert rst mid-stream -> all outputs 0 on the next edge.

Source files
------------

// File: rtl/mby_egr_pkg.sv
// Shared types and constants for the egress MC shared-table requester.
package mby_egr_pkg;

  localparam int unsigned MC_TBL_ADDR_W = 14;
  localparam int unsigned MC_TBL_DATA_W = 64;
  localparam int unsigned MC_TBL_TAG_W  = 3;

  typedef struct packed {
    logic [MC_TBL_ADDR_W-1:0] addr;
    logic [MC_TBL_TAG_W-1:0]  tag;
  } mc_tbl_req_t;

  typedef struct packed {
    logic [MC_TBL_TAG_W-1:0]  tag;
    logic [MC_TBL_DATA_W-1:0] data;
  } mc_tbl_rsp_t;

  typedef enum logic {StIdle, StIssue} mc_req_st_e;

endpackage

// File: rtl/mby_egr_rr_arb.sv
// Generic N-way round-robin arbiter: grants the first requester at or after the pointer,
// pointer moves past the winner when advance is asserted.
module mby_egr_rr_arb #(
  parameter int unsigned N = 4
) (
  input  logic         cclk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] gnt
);

  localparam int unsigned PTR_W = (N > 1) ? $clog2(N) : 1;

  logic [PTR_W-1:0] ptr_q, ptr_d, gnt_idx, sel;
  logic             found;
  int unsigned      pos;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    pos     = 0;
    sel     = '0;
    for (int unsigned i = 0; i < N; i++) begin
      pos = 32'(ptr_q) + i;
      if (pos >= N) pos = pos - N;
      sel = PTR_W'(pos);
      if (!found && req[sel]) begin
        found      = 1'b1;
        gnt[sel]   = 1'b1;
        gnt_idx    = sel;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance && found) begin
      ptr_d = (gnt_idx == PTR_W'(N - 1)) ? '0 : gnt_idx + PTR_W'(1);
    end
  end

  always_ff @(posedge cclk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/mby_egr_mc_table_req_arb.sv
// Egress MC shared-table requester: RR channel arbitration, tagged credit-limited requests,
// out-of-order response routing. Optional per-tag timeout via MBY_EGR_MC_TABLE_TIMEOUT_EN.
module mby_egr_mc_table_req_arb
  import mby_egr_pkg::*;
#(
  parameter int unsigned N_CH      = 4,
  parameter int unsigned ADDR_W    = MC_TBL_ADDR_W,
  parameter int unsigned DATA_W    = MC_TBL_DATA_W,
  parameter int unsigned MAX_OUTST = 8,
  parameter int unsigned TAG_W     = $clog2(MAX_OUTST),
  parameter int unsigned TMO_CYC   = 1024
) (
  input  logic                   cclk,
  input  logic                   rst,
  input  logic [N_CH-1:0]        ch_req_vld,
  input  logic [N_CH*ADDR_W-1:0] ch_req_addr,
  output logic [N_CH-1:0]        ch_req_rdy,
  output logic                   tbl_req_vld,
  output logic [ADDR_W-1:0]      tbl_req_addr,
  output logic [TAG_W-1:0]       tbl_req_tag,
  input  logic                   tbl_req_ack,
  input  logic                   tbl_rsp_vld,
  input  logic [TAG_W-1:0]       tbl_rsp_tag,
  input  logic [DATA_W-1:0]      tbl_rsp_data,
  output logic [N_CH-1:0]        ch_rsp_vld,
  output logic [DATA_W-1:0]      ch_rsp_data,
  output logic [TAG_W:0]         outst_cnt,
  output logic                   err_bad_tag,
  output logic                   err_timeout
);

  localparam int unsigned CH_W = $clog2(N_CH);

  mc_req_st_e            st_q, st_d;
  logic [MAX_OUTST-1:0]  alloc_q, alloc_d, tmo_free;
  logic [CH_W-1:0]       owner_q [MAX_OUTST];
  logic [ADDR_W-1:0]     req_addr_q, gnt_addr;
  logic [TAG_W-1:0]      req_tag_q, free_tag;
  logic [N_CH-1:0]       arb_req, rsp_vld_q;
  logic [DATA_W-1:0]     rsp_data_q;
  logic [CH_W-1:0]       gnt_ch;
  logic                  bad_tag_q, free_any, can_issue, grant, rsp_hit;

  // Lowest free tag; a tag freed this cycle is still marked allocated until the edge.
  always_comb begin
    free_any = 1'b0;
    free_tag = '0;
    for (int i = MAX_OUTST - 1; i >= 0; i--) begin
      if (!alloc_q[i]) begin
        free_any = 1'b1;
        free_tag = TAG_W'(i);
      end
    end
  end

  assign can_issue = !rst && ((st_q == StIdle) || tbl_req_ack) && free_any;
  assign arb_req   = ch_req_vld & {N_CH{can_issue}};
  assign grant     = |ch_req_rdy;

  mby_egr_rr_arb #(
    .N (N_CH)
  ) u_rr_arb (
    .cclk    (cclk),
    .rst     (rst),
    .req     (arb_req),
    .advance (grant),
    .gnt     (ch_req_rdy)
  );

  always_comb begin
    gnt_ch   = '0;
    gnt_addr = '0;
    for (int i = 0; i < int'(N_CH); i++) begin
      if (ch_req_rdy[i]) begin
        gnt_ch   = CH_W'(i);
        gnt_addr = ch_req_addr[i*ADDR_W +: ADDR_W];
      end
    end
  end

  assign rsp_hit = tbl_rsp_vld && alloc_q[tbl_rsp_tag];

  always_comb begin
    alloc_d = alloc_q & ~tmo_free;
    if (rsp_hit) alloc_d[tbl_rsp_tag] = 1'b0;
    if (grant)   alloc_d[free_tag]    = 1'b1;
  end

  always_comb begin
    st_d = st_q;
    if (grant)            st_d = StIssue;
    else if (tbl_req_ack) st_d = StIdle;
  end

  always_ff @(posedge cclk or posedge rst) begin
    if (rst) begin
      st_q       <= StIdle;
      alloc_q    <= '0;
      req_addr_q <= '0;
      req_tag_q  <= '0;
      rsp_vld_q  <= '0;
      rsp_data_q <= '0;
      bad_tag_q  <= 1'b0;
    end else begin
      st_q    <= st_d;
      alloc_q <= alloc_d;
      if (grant) begin
        req_addr_q <= gnt_addr;
        req_tag_q  <= free_tag;
      end
      rsp_vld_q <= rsp_hit ? (N_CH'(1) << owner_q[tbl_rsp_tag]) : '0;
      if (rsp_hit) rsp_data_q <= tbl_rsp_data;
      if (tbl_rsp_vld && !alloc_q[tbl_rsp_tag]) bad_tag_q <= 1'b1;
    end
  end

  // Owner entries are only meaningful while the tag is allocated, so no reset needed.
  always_ff @(posedge cclk) begin
    if (grant) owner_q[free_tag] <= gnt_ch;
  end

  always_comb begin
    outst_cnt = '0;
    for (int i = 0; i < int'(MAX_OUTST); i++) begin
      outst_cnt = outst_cnt + (TAG_W+1)'(alloc_q[i]);
    end
  end

`ifdef MBY_EGR_MC_TABLE_TIMEOUT_EN
  localparam int unsigned AGE_W = $clog2(TMO_CYC + 1);

  logic [AGE_W-1:0] age_q [MAX_OUTST];
  logic             tmo_q;

  // A response arriving in the expiry cycle wins over the timeout.
  always_comb begin
    for (int i = 0; i < int'(MAX_OUTST); i++) begin
      tmo_free[i] = alloc_q[i] && (age_q[i] == AGE_W'(TMO_CYC - 1)) &&
                    !(rsp_hit && (tbl_rsp_tag == TAG_W'(i)));
    end
  end

  always_ff @(posedge cclk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(MAX_OUTST); i++) age_q[i] <= '0;
      tmo_q <= 1'b0;
    end else begin
      for (int i = 0; i < int'(MAX_OUTST); i++) begin
        age_q[i] <= (alloc_q[i] && alloc_d[i]) ? age_q[i] + AGE_W'(1) : '0;
      end
      if (|tmo_free) tmo_q <= 1'b1;
    end
  end

  assign err_timeout = tmo_q;
`else
  logic unused_tmo_cyc;
  assign unused_tmo_cyc = (TMO_CYC == 0);
  assign tmo_free       = '0;
  assign err_timeout    = 1'b0;
`endif

  assign tbl_req_vld  = (st_q == StIssue);
  assign tbl_req_addr = req_addr_q;
  assign tbl_req_tag  = req_tag_q;
  assign ch_rsp_vld   = rsp_vld_q;
  assign ch_rsp_data  = rsp_data_q;
  assign err_bad_tag  = bad_tag_q;

endmodule

// File: tb/tb_mby_egr_mc_table_req_arb.sv
// Directed self-checking bench for mby_egr_mc_table_req_arb (4 channels, 8 tags).
module tb_mby_egr_mc_table_req_arb;

  logic        cclk = 1'b0;
  logic        rst;
  logic [3:0]  ch_req_vld;
  logic [55:0] ch_req_addr;
  logic [3:0]  ch_req_rdy;
  logic        tbl_req_vld;
  logic [13:0] tbl_req_addr;
  logic [2:0]  tbl_req_tag;
  logic        tbl_req_ack;
  logic        tbl_rsp_vld;
  logic [2:0]  tbl_rsp_tag;
  logic [63:0] tbl_rsp_data;
  logic [3:0]  ch_rsp_vld;
  logic [63:0] ch_rsp_data;
  logic [3:0]  outst_cnt;
  logic        err_bad_tag;
  logic        err_timeout;

  int vec_cnt = 0;
  int err_cnt = 0;

  localparam logic [63:0] DBASE = 64'hDEAD_BEEF_0000_0000;

  mby_egr_mc_table_req_arb #(
    .N_CH      (4),
    .ADDR_W    (14),
    .DATA_W    (64),
    .MAX_OUTST (8),
    .TAG_W     (3),
    .TMO_CYC   (16)
  ) dut (
    .cclk         (cclk),
    .rst          (rst),
    .ch_req_vld   (ch_req_vld),
    .ch_req_addr  (ch_req_addr),
    .ch_req_rdy   (ch_req_rdy),
    .tbl_req_vld  (tbl_req_vld),
    .tbl_req_addr (tbl_req_addr),
    .tbl_req_tag  (tbl_req_tag),
    .tbl_req_ack  (tbl_req_ack),
    .tbl_rsp_vld  (tbl_rsp_vld),
    .tbl_rsp_tag  (tbl_rsp_tag),
    .tbl_rsp_data (tbl_rsp_data),
    .ch_rsp_vld   (ch_rsp_vld),
    .ch_rsp_data  (ch_rsp_data),
    .outst_cnt    (outst_cnt),
    .err_bad_tag  (err_bad_tag),
    .err_timeout  (err_timeout)
  );

  always #5 cclk = ~cclk;

  task automatic tick();
    @(posedge cclk);
    #1;
  endtask

  task automatic clear_inputs();
    ch_req_vld   = '0;
    tbl_req_ack  = 1'b0;
    tbl_rsp_vld  = 1'b0;
    tbl_rsp_tag  = '0;
    tbl_rsp_data = '0;
    for (int i = 0; i < 4; i++) ch_req_addr[i*14 +: 14] = 14'(32'h100 + i);
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    vec_cnt++;
    if (ch_req_rdy !== 4'b0) begin
      err_cnt++; $display("FAIL reset_rdy got %b exp 0000", ch_req_rdy);
    end
    vec_cnt++;
    if ({tbl_req_vld, tbl_req_addr, tbl_req_tag} !== 18'h0) begin
      err_cnt++; $display("FAIL reset_tbl_req got %b/%h/%h exp 0", tbl_req_vld, tbl_req_addr,
                          tbl_req_tag);
    end
    vec_cnt++;
    if ({ch_rsp_vld, ch_rsp_data} !== 68'h0) begin
      err_cnt++; $display("FAIL reset_rsp got %b/%h exp 0", ch_rsp_vld, ch_rsp_data);
    end
    vec_cnt++;
    if ({outst_cnt, err_bad_tag, err_timeout} !== 6'h0) begin
      err_cnt++; $display("FAIL reset_status got %h/%b/%b exp 0", outst_cnt, err_bad_tag,
                          err_timeout);
    end
  endtask

  task automatic test_single();
    do_reset();
    ch_req_vld = 4'b0010;
    ch_req_addr[14 +: 14] = 14'h12;
    #1;
    vec_cnt++;
    if (ch_req_rdy !== 4'b0010) begin
      err_cnt++; $display("FAIL single_grant got %b exp 0010", ch_req_rdy);
    end
    tick();  // T+1
    ch_req_vld = '0;
    vec_cnt++;
    if ({tbl_req_vld, tbl_req_addr, tbl_req_tag} !== {1'b1, 14'h12, 3'd0}) begin
      err_cnt++; $display("FAIL single_issue got %b/%h/%h exp 1/12/0", tbl_req_vld,
                          tbl_req_addr, tbl_req_tag);
    end
    vec_cnt++;
    if (outst_cnt !== 4'd1) begin
      err_cnt++; $display("FAIL single_cnt1 got %0d exp 1", outst_cnt);
    end
    tick();  // T+2
    tick();  // T+3
    tbl_req_ack = 1'b1;
    vec_cnt++;
    if ({tbl_req_vld, tbl_req_addr} !== {1'b1, 14'h12}) begin
      err_cnt++; $display("FAIL single_hold got %b/%h exp 1/12", tbl_req_vld, tbl_req_addr);
    end
    tick();  // T+4
    tbl_req_ack = 1'b0;
    vec_cnt++;
    if (tbl_req_vld !== 1'b0) begin
      err_cnt++; $display("FAIL single_drop got %b exp 0", tbl_req_vld);
    end
    tick();  // T+5
    tick();  // T+6
    tbl_rsp_vld  = 1'b1;
    tbl_rsp_tag  = 3'd0;
    tbl_rsp_data = DBASE + 64'h55;
    tick();  // T+7
    tbl_rsp_vld = 1'b0;
    vec_cnt++;
    if ({ch_rsp_vld, ch_rsp_data} !== {4'b0010, DBASE + 64'h55}) begin
      err_cnt++; $display("FAIL single_rsp got %b/%h exp 0010/%h", ch_rsp_vld, ch_rsp_data,
                          DBASE + 64'h55);
    end
    vec_cnt++;
    if (outst_cnt !== 4'd0) begin
      err_cnt++; $display("FAIL single_cnt0 got %0d exp 0", outst_cnt);
    end
    tick();
    vec_cnt++;
    if (ch_rsp_vld !== 4'b0) begin
      err_cnt++; $display("FAIL single_rsp_pulse got %b exp 0000", ch_rsp_vld);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  exp_rdy;
    logic [13:0] exp_addr;
    do_reset();
    for (int k = 0; k <= 5; k++) begin
      ch_req_vld  = (k < 5) ? 4'b1111 : 4'b0000;
      tbl_req_ack = (k > 0);
      #1;
      exp_rdy = (k < 5) ? 4'(1 << (k % 4)) : 4'b0000;
      vec_cnt++;
      if (ch_req_rdy !== exp_rdy) begin
        err_cnt++; $display("FAIL b2b_grant%0d got %b exp %b", k, ch_req_rdy, exp_rdy);
      end
      if (k > 0) begin
        exp_addr = 14'(32'h100 + (k - 1) % 4);
        vec_cnt++;
        if ({tbl_req_vld, tbl_req_addr, tbl_req_tag} !== {1'b1, exp_addr, 3'(k - 1)}) begin
          err_cnt++; $display("FAIL b2b_req%0d got %b/%h/%0d exp 1/%h/%0d", k, tbl_req_vld,
                              tbl_req_addr, tbl_req_tag, exp_addr, k - 1);
        end
      end
      tick();
    end
    tbl_req_ack = 1'b0;
    vec_cnt++;
    if ({tbl_req_vld, outst_cnt} !== {1'b0, 4'd5}) begin
      err_cnt++; $display("FAIL b2b_end got %b/%0d exp 0/5", tbl_req_vld, outst_cnt);
    end
  endtask

  task automatic test_full();
    do_reset();
    ch_req_vld = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      tbl_req_ack = (k > 0);
      tick();
    end
    tbl_req_ack = 1'b1;  // cycle 8: tag 7 on the bus, all tags allocated
    #1;
    vec_cnt++;
    if ({ch_req_rdy, outst_cnt, tbl_req_tag} !== {4'b0000, 4'd8, 3'd7}) begin
      err_cnt++; $display("FAIL full_stall got %b/%0d/%0d exp 0000/8/7", ch_req_rdy, outst_cnt,
                          tbl_req_tag);
    end
    tick();  // cycle 9
    tbl_req_ack  = 1'b0;
    tbl_rsp_vld  = 1'b1;
    tbl_rsp_tag  = 3'd5;
    tbl_rsp_data = DBASE + 64'h5;
    #1;
    vec_cnt++;
    if ({tbl_req_vld, ch_req_rdy} !== {1'b0, 4'b0000}) begin
      err_cnt++; $display("FAIL full_same_cycle got %b/%b exp 0/0000", tbl_req_vld, ch_req_rdy);
    end
    tick();  // cycle 10
    tbl_rsp_vld = 1'b0;
    #1;
    vec_cnt++;
    if ({ch_rsp_vld, outst_cnt, ch_req_rdy} !== {4'b0010, 4'd7, 4'b0001}) begin
      err_cnt++; $display("FAIL full_free got %b/%0d/%b exp 0010/7/0001", ch_rsp_vld,
                          outst_cnt, ch_req_rdy);
    end
    tick();  // cycle 11
    ch_req_vld = '0;
    vec_cnt++;
    if ({tbl_req_vld, tbl_req_tag, outst_cnt, tbl_req_addr} !== {1'b1, 3'd5, 4'd8, 14'h100})
    begin
      err_cnt++; $display("FAIL full_regrant got %b/%0d/%0d/%h exp 1/5/8/100", tbl_req_vld,
                          tbl_req_tag, outst_cnt, tbl_req_addr);
    end
    tbl_req_ack = 1'b1;
    tick();
    tbl_req_ack = 1'b0;
  endtask

  task automatic test_out_of_order();
    logic [3:0] vlds [4];
    logic [3:0] grants [4];
    logic [2:0] tags [3];
    logic [3:0] owners [3];
    vlds   = '{4'b1100, 4'b1100, 4'b0011, 4'b0011};
    grants = '{4'b0100, 4'b1000, 4'b0001, 4'b0010};
    tags   = '{3'd3, 3'd0, 3'd2};
    owners = '{4'b0010, 4'b0100, 4'b0001};
    do_reset();
    for (int k = 0; k < 4; k++) begin
      ch_req_vld  = vlds[k];
      tbl_req_ack = (k > 0);
      #1;
      vec_cnt++;
      if (ch_req_rdy !== grants[k]) begin
        err_cnt++; $display("FAIL ooo_grant%0d got %b exp %b", k, ch_req_rdy, grants[k]);
      end
      tick();
    end
    ch_req_vld  = '0;
    tbl_req_ack = 1'b1;
    tick();
    tbl_req_ack = 1'b0;
    for (int r = 0; r < 3; r++) begin
      tbl_rsp_vld  = 1'b1;
      tbl_rsp_tag  = tags[r];
      tbl_rsp_data = DBASE + 64'(tags[r]);
      tick();
      tbl_rsp_vld = 1'b0;
      vec_cnt++;
      if ({ch_rsp_vld, ch_rsp_data} !== {owners[r], DBASE + 64'(tags[r])}) begin
        err_cnt++; $display("FAIL ooo_rsp_tag%0d got %b/%h exp %b/%h", tags[r], ch_rsp_vld,
                            ch_rsp_data, owners[r], DBASE + 64'(tags[r]));
      end
    end
    vec_cnt++;
    if (outst_cnt !== 4'd1) begin
      err_cnt++; $display("FAIL ooo_cnt got %0d exp 1", outst_cnt);
    end
  endtask

  task automatic test_bad_tag();
    tbl_rsp_vld = 1'b1;
    tbl_rsp_tag = 3'd6;
    tick();
    tbl_rsp_vld = 1'b0;
    vec_cnt++;
    if ({ch_rsp_vld, err_bad_tag, outst_cnt} !== {4'b0000, 1'b1, 4'd1}) begin
      err_cnt++; $display("FAIL bad_tag got %b/%b/%0d exp 0000/1/1", ch_rsp_vld, err_bad_tag,
                          outst_cnt);
    end
    tick();
    tick();
    vec_cnt++;
    if (err_bad_tag !== 1'b1) begin
      err_cnt++; $display("FAIL bad_tag_sticky got %b exp 1", err_bad_tag);
    end
  endtask

  task automatic test_reset_midstream();
    ch_req_vld = 4'b0001;
    tick();
    vec_cnt++;
    if ({tbl_req_vld, outst_cnt} !== {1'b1, 4'd2}) begin
      err_cnt++; $display("FAIL mid_pre got %b/%0d exp 1/2", tbl_req_vld, outst_cnt);
    end
    rst = 1'b1;
    tick();
    #1;
    vec_cnt++;
    if ({tbl_req_vld, outst_cnt, err_bad_tag, ch_rsp_vld, ch_req_rdy} !== 14'h0) begin
      err_cnt++; $display("FAIL mid_reset got %b/%0d/%b/%b/%b exp all 0", tbl_req_vld,
                          outst_cnt, err_bad_tag, ch_rsp_vld, ch_req_rdy);
    end
    rst = 1'b0;
    ch_req_vld = '0;
    tick();
    tbl_rsp_vld = 1'b1;
    tbl_rsp_tag = 3'd1;
    tick();
    tbl_rsp_vld = 1'b0;
    vec_cnt++;
    if ({ch_rsp_vld, err_bad_tag} !== {4'b0000, 1'b1}) begin
      err_cnt++; $display("FAIL mid_stale_rsp got %b/%b exp 0000/1", ch_rsp_vld, err_bad_tag);
    end
  endtask

`ifdef MBY_EGR_MC_TABLE_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    ch_req_vld = 4'b0001;
    tick();  // issue cycle
    ch_req_vld  = '0;
    tbl_req_ack = 1'b1;
    tick();
    tbl_req_ack = 1'b0;
    for (int i = 0; i < 14; i++) tick();
    vec_cnt++;
    if ({err_timeout, outst_cnt} !== {1'b0, 4'd1}) begin
      err_cnt++; $display("FAIL tmo_early got %b/%0d exp 0/1", err_timeout, outst_cnt);
    end
    tick();
    vec_cnt++;
    if ({err_timeout, outst_cnt, ch_rsp_vld} !== {1'b1, 4'd0, 4'b0000}) begin
      err_cnt++; $display("FAIL tmo_fire got %b/%0d/%b exp 1/0/0000", err_timeout, outst_cnt,
                          ch_rsp_vld);
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_single();
    test_back_to_back();
    test_full();
    test_out_of_order();
    test_bad_tag();
    test_reset_midstream();
`ifdef MBY_EGR_MC_TABLE_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
